byte_deserializer: RTL

Serial-to-parallel front end for the 8-bit enable-loaded holding register. Collects a framed, MSB-first serial bit stream plus one even-parity bit, and presents the assembled byte on `data` with a one-cycle `ena` strobe that drives the register's load enable directly. Bad parity and broken frames are flagged and never loaded.

---
 rtl/deser_pkg.sv | 10 +
 rtl/byte_deserializer_bit_counter.sv | 34 +++
 rtl/byte_deserializer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/deser_pkg.sv
// Shared types and defaults for the serial byte deserializer.
//   deser_state_t : framing FSM states
//   DEFAULT_WIDTH : data bits per frame when not overridden
package deser_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, PAR} deser_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/byte_deserializer_bit_counter.sv
// bit_counter: loadable up-counter that tracks bits received in a frame.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous reset, active low
//   i_load1 : synchronous load to 1 (first bit of a frame); wins over i_inc
//   i_inc   : increment enable
//   o_cnt   : current count
//   o_tc    : terminal flag, high when o_cnt == WIDTH
module bit_counter
  import deser_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load1,
  input  logic          i_inc,
  output logic [CW-1:0] o_cnt,
  output logic          o_tc
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_cnt <= '0;
    else if (i_load1) r_cnt <= CW'(1);
    else if (i_inc)   r_cnt <= r_cnt + CW'(1);
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == CW'(WIDTH));

endmodule

// File: rtl/byte_deserializer.sv
// byte_deserializer: framed MSB-first serial-to-parallel converter with
// optional even parity. A good frame updates data and pulses ena for one
// cycle; a parity mismatch pulses perr, an sof arriving mid-frame pulses ferr.
// Ports:
//   clk, rst : clock (rising edge) and async active-low reset
//   sin      : serial bit, sampled when sin_vld is high
//   sin_vld  : bit strobe, one bit consumed per high cycle
//   sof      : start of frame (qualified by sin_vld); marks the MSB
//   data     : last good byte, held between loads
//   ena      : one-cycle load strobe for data
//   perr     : one-cycle parity error pulse
//   ferr     : one-cycle framing error pulse (frame aborted by sof)
//   busy     : frame in progress
module byte_deserializer
  import deser_pkg::*;
#(
  parameter  int WIDTH     = DEFAULT_WIDTH,
  parameter  bit PARITY_EN = 1'b1,
  localparam int CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_vld,
  input  logic             sof,
  output logic [WIDTH-1:0] data,
  output logic             ena,
  output logic             perr,
  output logic             ferr,
  output logic             busy
);

  deser_state_t   r_state, w_nxt;
  logic [WIDTH-1:0] r_shreg, r_data, w_shnext;
  logic           r_ena, r_perr, r_ferr;
  logic           w_shift, w_load1, w_inc, w_emit, w_perr, w_ferr;
  logic [CW-1:0]  w_cnt;
  logic           w_tc, w_par_ok;

  bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_load1 (w_load1),
    .i_inc   (w_inc),
    .o_cnt   (w_cnt),
    .o_tc    (w_tc)
  );

  generate
    if (WIDTH == 1) begin : g_sh1
      assign w_shnext = sin;
    end else begin : g_shn
      assign w_shnext = {r_shreg[WIDTH-2:0], sin};
    end
  endgenerate

  // Parity bit is only meaningful once the counter reports a full byte.
  assign w_par_ok = w_tc & ~(^r_shreg ^ sin);

  always_comb begin
    w_nxt   = r_state;
    w_shift = 1'b0;
    w_load1 = 1'b0;
    w_inc   = 1'b0;
    w_emit  = 1'b0;
    w_perr  = 1'b0;
    w_ferr  = 1'b0;
    if (sin_vld) begin
      if (sof) begin
        // sof always restarts; it is only an error if a frame was open.
        w_ferr  = (r_state != IDLE);
        w_shift = 1'b1;
        w_load1 = 1'b1;
        if (WIDTH == 1) begin
          if (PARITY_EN) w_nxt = PAR;
          else begin
            w_emit = 1'b1;
            w_nxt  = IDLE;
          end
        end else begin
          w_nxt = SHIFT;
        end
      end else begin
        unique case (r_state)
          IDLE: w_nxt = IDLE;
          SHIFT: begin
            w_shift = 1'b1;
            w_inc   = 1'b1;
            if (w_cnt == CW'(WIDTH - 1)) begin
              if (PARITY_EN) w_nxt = PAR;
              else begin
                w_emit = 1'b1;
                w_nxt  = IDLE;
              end
            end
          end
          PAR: begin
            if (w_par_ok) w_emit = 1'b1;
            else          w_perr = 1'b1;
            w_nxt = IDLE;
          end
          default: w_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_data  <= '0;
      r_ena   <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_shift) r_shreg <= w_shnext;
      // Without parity the final data bit is still in flight, so take the
      // shifted value; in PAR the register already holds the whole byte.
      if (w_emit)  r_data  <= w_shift ? w_shnext : r_shreg;
      r_ena   <= w_emit;
      r_perr  <= w_perr;
      r_ferr  <= w_ferr;
    end
  end

  assign data = r_data;
  assign ena  = r_ena;
  assign perr = r_perr;
  assign ferr = r_ferr;
  assign busy = (r_state != IDLE);

endmodule
